// File: rtl/ntsc_pkg.sv
// Shared timing constants, output levels and the line-state encoding for the
// 4fsc NTSC composite path.
package ntsc_pkg;

    localparam int HCNT_W = 10;

    // Line timing in 4fsc clocks
    localparam logic [HCNT_W-1:0] C_LINE_LEN  = 10'd910;
    localparam logic [HCNT_W-1:0] C_SYNC_LEN  = 10'd67;
    localparam logic [HCNT_W-1:0] C_BURST_STA = 10'd76;
    localparam logic [HCNT_W-1:0] C_BURST_LEN = 10'd36;
    localparam logic [HCNT_W-1:0] C_ACT_STA   = 10'd150;
    localparam logic [HCNT_W-1:0] C_ACT_LEN   = 10'd720;
    localparam logic [HCNT_W-1:0] C_PIPE_LAT  = 10'd2;

    localparam logic [HCNT_W-1:0] C_BURST_END = C_BURST_STA + C_BURST_LEN;
    localparam logic [HCNT_W-1:0] C_ACT_END   = C_ACT_STA + C_ACT_LEN;
    // Fetch window leads the active window by the converter latency
    localparam logic [HCNT_W-1:0] C_REQ_STA   = C_ACT_STA - C_PIPE_LAT;
    localparam logic [HCNT_W-1:0] C_REQ_END   = C_ACT_END - C_PIPE_LAT;

    // Output codes and gains
    localparam logic [7:0] C_SYNC_LVL  = 8'd4;
    localparam logic [7:0] C_BLANK_LVL = 8'd60;
    localparam logic [7:0] C_BURST_AMP = 8'd20;
    localparam logic [7:0] C_Y_GAIN    = 8'd150;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_BP1    = 3'd1,
        ST_BURST  = 3'd2,
        ST_BP2    = 3'd3,
        ST_ACTIVE = 3'd4,
        ST_FP     = 3'd5
    } state_t;

    // Line region for a given position; a vblank line never enters ACTIVE
    function automatic state_t decode_state(input logic [HCNT_W-1:0] h,
                                            input logic vbl);
        state_t s;
        if (h < C_SYNC_LEN)
            s = ST_SYNC;
        else if (h < C_BURST_STA)
            s = ST_BP1;
        else if (h < C_BURST_END)
            s = ST_BURST;
        else if (h < C_ACT_STA)
            s = ST_BP2;
        else if ((h < C_ACT_END) && !vbl)
            s = ST_ACTIVE;
        else
            s = ST_FP;
        return s;
    endfunction

endpackage

// File: rtl/ntsc_comp_mix.sv
// Combinational composite mixer: picks the chroma/burst term for the current
// subcarrier phase, adds level and scaled luma, and clamps to the DAC range.
module ntsc_comp_mix
    import ntsc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  state_t                    state,
    input  logic [1:0]                ph,
    input  logic [DATA_W-1:0]         yy,
    input  logic signed [DATA_W-1:0]  uu,
    input  logic signed [DATA_W-1:0]  vv,
    output logic [DATA_W-1:0]         video
);

    // Headroom for level + luma + chroma/2, including a negative excursion
    localparam int SUM_W = DATA_W + 3;

    logic [DATA_W+COEF_W-1:0] y_prod;
    logic [DATA_W-1:0]        y_term;
    logic signed [DATA_W:0]   chroma;
    logic signed [DATA_W:0]   chroma_half;
    logic signed [DATA_W:0]   burst;
    logic signed [SUM_W-1:0]  sum;

    // Clamp an out-of-range signed sum to [0, 2^DATA_W-1]
    function automatic logic [DATA_W-1:0] sat_unsigned(input logic signed [SUM_W-1:0] x);
        logic [DATA_W-1:0] r;
        if (x[SUM_W-1])
            r = '0;
        else if (|x[SUM_W-2:DATA_W])
            r = '1;
        else
            r = x[DATA_W-1:0];
        return r;
    endfunction

    // Luma scale (Q0.8 gain) and phase-selected chroma/burst terms
    always_comb begin
        y_prod = yy * C_Y_GAIN;
        y_term = y_prod[DATA_W+COEF_W-1:COEF_W];
        chroma = '0;
        burst  = '0;
        // Negation is done at DATA_W+1 bits so -(-128) stays +128
        case (ph)
            2'd0: chroma = $signed({uu[DATA_W-1], uu});
            2'd1: chroma = $signed({vv[DATA_W-1], vv});
            2'd2: chroma = -$signed({uu[DATA_W-1], uu});
            default: chroma = -$signed({vv[DATA_W-1], vv});
        endcase
        case (ph)
            2'd0: burst = -$signed({1'b0, C_BURST_AMP});
            2'd2: burst = $signed({1'b0, C_BURST_AMP});
            default: burst = '0;
        endcase
        chroma_half = chroma >>> 1;
    end

    // Region-dependent composite sum, then clamp
    always_comb begin
        sum = $signed({{(SUM_W-DATA_W){1'b0}}, C_BLANK_LVL});
        case (state)
            ST_SYNC:
                sum = $signed({{(SUM_W-DATA_W){1'b0}}, C_SYNC_LVL});
            ST_BURST:
                sum = $signed({{(SUM_W-DATA_W){1'b0}}, C_BLANK_LVL})
                    + $signed({{(SUM_W-DATA_W-1){burst[DATA_W]}}, burst});
            ST_ACTIVE:
                sum = $signed({{(SUM_W-DATA_W){1'b0}}, C_BLANK_LVL})
                    + $signed({{(SUM_W-DATA_W){1'b0}}, y_term})
                    + $signed({{(SUM_W-DATA_W-1){chroma_half[DATA_W]}}, chroma_half});
            default:
                sum = $signed({{(SUM_W-DATA_W){1'b0}}, C_BLANK_LVL});
        endcase
        video = sat_unsigned(sum);
    end

endmodule

// File: rtl/ntsc_comp_seq.sv
// NTSC line sequencer and composite encoder: line/phase counters, registered
// line-region FSM, pixel-fetch strobe and the registered composite sample.
module ntsc_comp_seq
    import ntsc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic                      CK_i,
    input  logic                      AR_i,
    input  logic                      CK_EE_i,
    input  logic                      LINE_STA_i,
    input  logic                      VBLANK_i,
    input  logic [DATA_W-1:0]         YYs_i,
    input  logic signed [DATA_W-1:0]  UUs_i,
    input  logic signed [DATA_W-1:0]  VVs_i,
    output logic                      RD_REQ_o,
    output logic [HCNT_W-1:0]         HCNTs_o,
    output logic [1:0]                PHs_o,
    output logic [DATA_W-1:0]         VIDEOs_o
);

    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic [1:0]        ph;
    logic              vbl_lat, vbl_nxt;
    logic              rd_req, rd_req_nxt;
    state_t            state, state_nxt;
    logic [DATA_W-1:0] video_p0;
    logic [DATA_W-1:0] video_p1;

    // Next line position, vblank latch and region; line start beats wrap
    always_comb begin
        hcnt_nxt = hcnt + 10'd1;
        vbl_nxt  = vbl_lat;
        if (LINE_STA_i) begin
            hcnt_nxt = '0;
            vbl_nxt  = VBLANK_i;
        end else if (hcnt == C_LINE_LEN - 10'd1) begin
            hcnt_nxt = '0;
        end
        state_nxt  = decode_state(hcnt_nxt, vbl_nxt);
        rd_req_nxt = !vbl_nxt && (hcnt_nxt >= C_REQ_STA) && (hcnt_nxt < C_REQ_END);
    end

    // Counters, latch, strobe and state advance only on enabled clocks
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            hcnt    <= '0;
            ph      <= '0;
            vbl_lat <= 1'b0;
            rd_req  <= 1'b0;
            state   <= ST_SYNC;
        end else if (CK_EE_i) begin
            hcnt    <= hcnt_nxt;
            ph      <= ph + 2'd1;
            vbl_lat <= vbl_nxt;
            rd_req  <= rd_req_nxt;
            state   <= state_nxt;
        end
    end

    // ---- stage p0: composite mix of current state, phase and pixel ----
    ntsc_comp_mix #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_mix (
        .state (state),
        .ph    (ph),
        .yy    (YYs_i),
        .uu    (UUs_i),
        .vv    (VVs_i),
        .video (video_p0)
    );

    // ---- stage p1: registered DAC sample ----
    // Output sample register; cleared by reset so an aborted line emits nothing
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i)
            video_p1 <= '0;
        else if (CK_EE_i)
            video_p1 <= video_p0;
    end

    assign RD_REQ_o = rd_req;
    assign HCNTs_o  = hcnt;
    assign PHs_o    = ph;
    assign VIDEOs_o = video_p1;

endmodule

// File: tb/tb_ntsc_comp_seq.sv
// Directed bench for ntsc_comp_seq with hand-computed expected samples.
module tb_ntsc_comp_seq;

    logic        CK_i = 1'b0;
    logic        AR_i;
    logic        CK_EE_i;
    logic        LINE_STA_i;
    logic        VBLANK_i;
    logic [7:0]  YYs_i;
    logic signed [7:0] UUs_i;
    logic signed [7:0] VVs_i;
    logic        RD_REQ_o;
    logic [9:0]  HCNTs_o;
    logic [1:0]  PHs_o;
    logic [7:0]  VIDEOs_o;

    int n_cmp = 0;
    int n_bad = 0;
    int vid[910];
    int ph_at[910];
    int sync_cnt, rd_cnt, rd_first, last_h;
    int ph_exp;
    int cycles;
    int hold_v;
    bit done;

    ntsc_comp_seq dut (
        .CK_i       (CK_i),
        .AR_i       (AR_i),
        .CK_EE_i    (CK_EE_i),
        .LINE_STA_i (LINE_STA_i),
        .VBLANK_i   (VBLANK_i),
        .YYs_i      (YYs_i),
        .UUs_i      (UUs_i),
        .VVs_i      (VVs_i),
        .RD_REQ_o   (RD_REQ_o),
        .HCNTs_o    (HCNTs_o),
        .PHs_o      (PHs_o),
        .VIDEOs_o   (VIDEOs_o)
    );

    always #5 CK_i = ~CK_i;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected burst sample for a subcarrier phase
    function automatic int burst_exp(input int p);
        return (p == 0) ? 40 : (p == 2) ? 80 : 60;
    endfunction

    // Pixel pattern keyed on line position
    task automatic drive_pix(input int h);
        if (h >= 300 && h < 304) begin
            YYs_i = 8'd255; UUs_i = 8'sd127; VVs_i = 8'sd127;
        end else if (h >= 400 && h < 404) begin
            YYs_i = 8'd0; UUs_i = -8'sd128; VVs_i = 8'sd0;
        end else if (h >= 500 && h < 504) begin
            YYs_i = 8'd128; UUs_i = 8'sd0; VVs_i = 8'sd0;
        end else begin
            YYs_i = 8'd0; UUs_i = 8'sd40; VVs_i = -8'sd40;
        end
    endtask

    // One enabled clock, then sample
    task automatic tick();
        @(posedge CK_i);
        #1;
        ph_exp = (ph_exp + 1) % 4;
    endtask

    // Run enabled clocks, recording the sample produced for each position
    task automatic run_line(input int nsteps);
        int h;
        sync_cnt = 0; rd_cnt = 0; rd_first = -1;
        for (int i = 0; i < nsteps; i++) begin
            h = int'(HCNTs_o);
            if (h < 910) ph_at[h] = ph_exp;
            drive_pix(h);
            tick();
            if (h < 910) vid[h] = int'(VIDEOs_o);
            if (VIDEOs_o == 8'd4) sync_cnt++;
            if (RD_REQ_o) begin
                if (rd_first < 0) rd_first = int'(HCNTs_o);
                rd_cnt++;
            end
            last_h = h;
        end
    endtask

    task automatic line_start(input logic vb);
        LINE_STA_i = 1'b1;
        VBLANK_i   = vb;
        tick();
        LINE_STA_i = 1'b0;
        VBLANK_i   = 1'b0;
    endtask

    initial begin
        AR_i = 1'b1; CK_EE_i = 1'b1; LINE_STA_i = 1'b0; VBLANK_i = 1'b0;
        YYs_i = '0; UUs_i = '0; VVs_i = '0;
        ph_exp = 0;
        repeat (3) @(posedge CK_i);
        #1;
        chk("rst_hcnt", int'(HCNTs_o), 0);
        chk("rst_ph", int'(PHs_o), 0);
        chk("rst_video", int'(VIDEOs_o), 0);
        chk("rst_rdreq", int'(RD_REQ_o), 0);
        AR_i = 1'b0;

        // Line 1: free-running timing, burst and chroma
        run_line(910);
        chk("l1_last_hcnt", last_h, 909);
        chk("l1_wrap_hcnt", int'(HCNTs_o), 0);
        chk("l1_sync_count", sync_cnt, 67);
        chk("l1_sync_end", vid[66], 4);
        chk("l1_bp1_start", vid[67], 60);
        chk("l1_rd_first", rd_first, 148);
        chk("l1_rd_count", rd_cnt, 720);
        chk("l1_burst76", vid[76], 40);
        chk("l1_burst77", vid[77], 60);
        chk("l1_burst78", vid[78], 80);
        chk("l1_burst79", vid[79], 60);
        chk("l1_chroma_ph0", vid[152], 80);
        chk("l1_chroma_ph1", vid[153], 40);
        chk("l1_chroma_ph2", vid[154], 40);
        chk("l1_chroma_ph3", vid[155], 80);
        chk("l1_clamp_hi_ph0", vid[300], 255);
        chk("l1_clamp_hi_ph1", vid[301], 255);
        chk("l1_clamp_lo_ph0", vid[400], 0);
        chk("l1_neg128_ph2", vid[402], 124);
        chk("l1_luma_gain", vid[500], 135);
        chk("l1_fp", vid[880], 60);
        chk("l1_ph", int'(PHs_o), ph_exp);

        // Line 2: subcarrier flipped by 180 degrees
        run_line(910);
        chk("l2_burst76", vid[76], 80);
        chk("l2_burst77", vid[77], 60);
        chk("l2_burst78", vid[78], 40);
        chk("l2_burst79", vid[79], 60);
        chk("l2_rd_count", rd_cnt, 720);

        // Line 3: vblank line
        line_start(1'b1);
        run_line(910);
        chk("vb_rd_count", rd_cnt, 0);
        chk("vb_active152", vid[152], 60);
        chk("vb_active300", vid[300], 60);
        chk("vb_sync_count", sync_cnt, 67);
        chk("vb_burst76", vid[76], burst_exp(ph_at[76]));
        chk("vb_burst78", vid[78], burst_exp(ph_at[78]));
        chk("vb_ph", int'(PHs_o), ph_exp);

        // Line 4: truncated by a line start inside ACTIVE
        line_start(1'b0);
        run_line(500);
        chk("tr_pre_hcnt", int'(HCNTs_o), 500);
        chk("tr_pre_rdreq", int'(RD_REQ_o), 1);
        line_start(1'b0);
        chk("tr_hcnt", int'(HCNTs_o), 0);
        chk("tr_rdreq", int'(RD_REQ_o), 0);
        tick();
        chk("tr_sync", int'(VIDEOs_o), 4);

        // Asynchronous reset in the middle of ACTIVE
        run_line(199);
        chk("ar_pre_hcnt", int'(HCNTs_o), 200);
        #2;
        AR_i = 1'b1;
        #1;
        chk("ar_video", int'(VIDEOs_o), 0);
        chk("ar_rdreq", int'(RD_REQ_o), 0);
        chk("ar_hcnt", int'(HCNTs_o), 0);
        chk("ar_ph", int'(PHs_o), 0);
        @(posedge CK_i);
        @(posedge CK_i);
        #1;
        AR_i = 1'b0;
        ph_exp = 0;

        // Half-rate enable: one line spans 1820 clocks; gated line start ignored
        cycles = 0;
        done = 1'b0;
        hold_v = 0;
        while (!done && cycles < 4000) begin
            CK_EE_i = (cycles % 2 == 1);
            if (cycles == 100) begin
                LINE_STA_i = 1'b1;
                hold_v = int'(VIDEOs_o);
            end
            @(posedge CK_i);
            #1;
            if (cycles == 100) begin
                chk("ee_hold_hcnt", int'(HCNTs_o), 50);
                chk("ee_hold_ph", int'(PHs_o), 2);
                chk("ee_hold_video", int'(VIDEOs_o), hold_v);
                LINE_STA_i = 1'b0;
            end
            cycles++;
            if (HCNTs_o == 10'd0 && cycles > 1) done = 1'b1;
        end
        chk("ee_line_clocks", cycles, 1820);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
